// File: rtl/time_set_ctrl_if.sv
// Bundle between the time-setting controller and the digit counter / display.
// The controller side is the master; the counter/button side is the slave.
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_left;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] sec0;
    logic [3:0] sec1;
    logic [3:0] min0;
    logic [3:0] min1;
    logic [3:0] hrs0;
    logic [3:0] hrs1;
    logic       set_active;
    logic [5:0] cursor;
    logic [3:0] n_sec0;
    logic [3:0] n_sec1;
    logic [3:0] n_min0;
    logic [3:0] n_min1;
    logic [3:0] n_hrs0;
    logic [3:0] n_hrs1;
    logic [5:0] blank;

    modport master (
        input  btn_mode, btn_left, btn_up, btn_down,
        input  sec0, sec1, min0, min1, hrs0, hrs1,
        output set_active, cursor,
        output n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1,
        output blank
    );

    modport slave (
        output btn_mode, btn_left, btn_up, btn_down,
        output sec0, sec1, min0, min1, hrs0, hrs1,
        input  set_active, cursor,
        input  n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1,
        input  blank
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Push-button time-setting controller: edits a shadow copy of the BCD time and
// commits it digit by digit to the counter. Define TSET_BLINK_EN to build the blink mask.
module time_set_ctrl #(
    parameter int TIMEOUT    = 30,
    parameter int BLINK_HALF = 1
) (
    input logic            clk,
    input logic            rst_n,
    time_set_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET,
        ST_COMMIT
    } state_e;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_MODE,
        ACT_LEFT,
        ACT_UP,
        ACT_DOWN
    } action_e;

    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Shadow digit index: 0=sec0 1=sec1 2=min0 3=min1 4=hrs0 5=hrs1.
    function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] hrs1);
        case (idx)
            3'd0:    digit_max = 4'd9;
            3'd1:    digit_max = 4'd5;
            3'd2:    digit_max = 4'd9;
            3'd3:    digit_max = 4'd5;
            3'd4:    digit_max = (hrs1 == 4'd2) ? 4'd3 : 4'd9;
            3'd5:    digit_max = 4'd2;
            default: digit_max = 4'd9;
        endcase
    endfunction

    logic [3:0] btn_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] prev_q;
    logic [3:0] pulse;
    action_e    act;

    state_e            state_q, state_d;
    logic [5:0][3:0]   shadow_q, shadow_d;
    logic [5:0]        cursor_q, cursor_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [2:0]        sel_idx;
    logic [3:0]        sel_digit;
    logic [3:0]        sel_max;
    logic              edited;
    logic              blink_restart;

    assign btn_raw = {bus.btn_mode, bus.btn_left, bus.btn_up, bus.btn_down};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~prev_q;

    // Only one press is honoured per cycle; lower-priority pulses are dropped.
    always_comb begin
        if (pulse[3])      act = ACT_MODE;
        else if (pulse[2]) act = ACT_LEFT;
        else if (pulse[1]) act = ACT_UP;
        else if (pulse[0]) act = ACT_DOWN;
        else               act = ACT_NONE;
    end

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (cursor_q[i]) sel_idx = 3'(i);
        end
    end

    assign sel_digit = shadow_q[sel_idx];
    assign sel_max   = digit_max(sel_idx, shadow_q[5]);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        cursor_d      = cursor_q;
        idle_d        = idle_q;
        edited        = 1'b0;
        blink_restart = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (act == ACT_MODE) begin
                    state_d       = ST_SET;
                    shadow_d      = {bus.hrs1, bus.hrs0, bus.min1, bus.min0, bus.sec1, bus.sec0};
                    cursor_d      = 6'b000001;
                    idle_d        = '0;
                    blink_restart = 1'b1;
                end
            end

            ST_SET: begin
                case (act)
                    ACT_MODE: begin
                        state_d  = ST_COMMIT;
                        cursor_d = 6'b000001;
                    end
                    ACT_LEFT: begin
                        cursor_d      = {cursor_q[4:0], cursor_q[5]};
                        idle_d        = '0;
                        blink_restart = 1'b1;
                    end
                    ACT_UP: begin
                        shadow_d[sel_idx] = (sel_digit >= sel_max) ? 4'd0 : sel_digit + 4'd1;
                        edited            = 1'b1;
                        idle_d            = '0;
                    end
                    ACT_DOWN: begin
                        shadow_d[sel_idx] = (sel_digit == 4'd0 || sel_digit > sel_max)
                                            ? sel_max : sel_digit - 4'd1;
                        edited            = 1'b1;
                        idle_d            = '0;
                    end
                    default: begin
                        if (idle_q == IDLE_LAST) begin
                            if (TIMEOUT != 0) begin
                                state_d  = ST_COMMIT;
                                cursor_d = 6'b000001;
                            end
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
                    end
                endcase
                // Raising the tens of hours to 2 must drag the units into 20..23.
                if (edited && shadow_d[5] == 4'd2 && shadow_d[4] > 4'd3) begin
                    shadow_d[4] = 4'd3;
                end
            end

            ST_COMMIT: begin
                if (cursor_q[5]) begin
                    state_d  = ST_RUN;
                    cursor_d = '0;
                end else begin
                    cursor_d = {cursor_q[4:0], 1'b0};
                end
            end

            default: begin
                state_d  = ST_RUN;
                cursor_d = '0;
            end
        endcase
    end

    // NOTE: the shadow digits are reset like any other state because they drive n_* directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            shadow_q <= '0;
            cursor_q <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cursor_q <= cursor_d;
            idle_q   <= idle_d;
        end
    end

    assign bus.set_active = (state_q != ST_RUN);
    assign bus.cursor     = cursor_q;
    assign bus.n_sec0     = shadow_q[0];
    assign bus.n_sec1     = shadow_q[1];
    assign bus.n_min0     = shadow_q[2];
    assign bus.n_min1     = shadow_q[3];
    assign bus.n_hrs0     = shadow_q[4];
    assign bus.n_hrs1     = shadow_q[5];

`ifdef TSET_BLINK_EN
    localparam int BLINK_W = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'((BLINK_HALF > 0) ? BLINK_HALF - 1 : 0);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    // Phase 0 is visible; a restart always shows the digit before hiding it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_restart) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (state_q == ST_SET) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign bus.blank = (state_q == ST_SET && blink_phase_q) ? cursor_q : '0;
`else
    logic blink_unused;
    assign blink_unused = blink_restart | (BLINK_HALF > 0);
    assign bus.blank    = '0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised bench for time_set_ctrl against a digit-level reference model,
// with directed scenarios pinned to hand-computed values.
module tb_time_set_ctrl;
    localparam int TO = 30;
    localparam int BH = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] btn = 4'b0;              // {mode, left, up, down}
    logic [3:0] tdig [6] = '{default: 4'd0};      // counter digits, sec0..hrs1
    logic [3:0] next_time [6] = '{default: 4'd0};
    int req_seq  = 0;
    int seen_seq = 0;
    logic [3:0] nout [6];

    int checks   = 0;
    int failures = 0;

    time_set_ctrl_if bus();

    time_set_ctrl #(.TIMEOUT(TO), .BLINK_HALF(BH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.btn_mode = btn[3];
    assign bus.btn_left = btn[2];
    assign bus.btn_up   = btn[1];
    assign bus.btn_down = btn[0];
    assign bus.sec0 = tdig[0];
    assign bus.sec1 = tdig[1];
    assign bus.min0 = tdig[2];
    assign bus.min1 = tdig[3];
    assign bus.hrs0 = tdig[4];
    assign bus.hrs1 = tdig[5];
    assign nout[0] = bus.n_sec0;
    assign nout[1] = bus.n_sec1;
    assign nout[2] = bus.n_min0;
    assign nout[3] = bus.n_min1;
    assign nout[4] = bus.n_hrs0;
    assign nout[5] = bus.n_hrs1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=RUN 1=SET 2=COMMIT, cursor kept as a digit index.
    int m_mode;
    int m_idx;
    int m_step;
    int m_idle;
    int m_sh [6];
    logic [3:0] m_hist [3];
    int m_bcnt;
    int m_phase;

    function automatic int max_of(input int i);
        case (i)
            0: return 9;
            1: return 5;
            2: return 9;
            3: return 5;
            4: return (m_sh[5] == 2) ? 3 : 9;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_step = 0; m_idle = 0;
        m_bcnt = 0; m_phase = 0;
        for (int i = 0; i < 6; i++) m_sh[i] = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = 4'b0;
    endtask

    task automatic model_step();
        logic [3:0] p;
        int a;
        int mx;
        // A level first sampled at edge n-2 after a low sample at n-3 acts at edge n.
        p = m_hist[1] & ~m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = btn;
        a = p[3] ? 1 : p[2] ? 2 : p[1] ? 3 : p[0] ? 4 : 0;
        case (m_mode)
            0: if (a == 1) begin
                m_mode = 1; m_idx = 0; m_idle = 0; m_bcnt = 0; m_phase = 0;
                for (int i = 0; i < 6; i++) m_sh[i] = int'(tdig[i]);
            end
            1: begin
                m_bcnt++;
                if (m_bcnt == BH) begin m_bcnt = 0; m_phase = 1 - m_phase; end
                if (a == 1) begin
                    m_mode = 2; m_step = 0;
                end else if (a == 2) begin
                    m_idx = (m_idx + 1) % 6; m_idle = 0; m_bcnt = 0; m_phase = 0;
                end else if (a == 3 || a == 4) begin
                    mx = max_of(m_idx);
                    if (a == 3) m_sh[m_idx] = (m_sh[m_idx] == mx) ? 0 : m_sh[m_idx] + 1;
                    else        m_sh[m_idx] = (m_sh[m_idx] == 0) ? mx : m_sh[m_idx] - 1;
                    if (m_sh[5] == 2 && m_sh[4] > 3) m_sh[4] = 3;
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (TO != 0 && m_idle == TO) begin m_mode = 2; m_step = 0; end
                end
            end
            default: begin
                m_step++;
                if (m_step == 6) m_mode = 0;
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    function automatic logic [5:0] exp_cursor();
        if (m_mode == 1) return 6'(1 << m_idx);
        if (m_mode == 2) return 6'(1 << m_step);
        return 6'b0;
    endfunction

    function automatic logic [5:0] exp_blank();
`ifdef TSET_BLINK_EN
        if (m_mode == 1 && m_phase == 1) return exp_cursor();
`endif
        return 6'b0;
    endfunction

    always @(negedge clk) begin
        check("set_active", 32'(bus.set_active), 32'(m_mode != 0));
        check("cursor", 32'(bus.cursor), 32'(exp_cursor()));
        for (int i = 0; i < 6; i++) check($sformatf("n_digit%0d", i), 32'(nout[i]), m_sh[i]);
        check("blank", 32'(bus.blank), 32'(exp_blank()));
    end

    // Digit counter stand-in: loads the cursor-selected digit while held.
    always @(negedge clk) begin
        if (bus.set_active) begin
            for (int i = 0; i < 6; i++) if (bus.cursor[i]) tdig[i] <= nout[i];
        end else if (req_seq != seen_seq) begin
            for (int i = 0; i < 6; i++) tdig[i] <= next_time[i];
            seen_seq <= req_seq;
        end
    end

    task automatic press(input logic [3:0] mask);
        @(negedge clk); btn = mask;
        @(negedge clk); btn = 4'b0;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                            input int s1, input int s0);
        next_time[0] = 4'(s0); next_time[1] = 4'(s1);
        next_time[2] = 4'(m0); next_time[3] = 4'(m1);
        next_time[4] = 4'(h0); next_time[5] = 4'(h1);
        req_seq++;
    endtask

    initial begin
        int exp_cap [6];
        int exp_new [6];
        logic [3:0] mask;
        int h1;
        exp_cap = '{6, 5, 4, 3, 2, 1};
        exp_new = '{6, 5, 4, 3, 3, 0};

        set_time(1, 2, 3, 4, 5, 6);
        #1 rst_n = 1'b0;
        #12;
        check("reset set_active", 32'(bus.set_active), 0);
        check("reset cursor", 32'(bus.cursor), 0);
        check("reset n_hrs1", 32'(bus.n_hrs1), 0);
        check("reset blank", 32'(bus.blank), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        press(4'b1000);
        check("enter set_active", 32'(bus.set_active), 1);
        check("enter cursor", 32'(bus.cursor), 1);
        for (int i = 0; i < 6; i++) check($sformatf("capture digit%0d", i), 32'(nout[i]), exp_cap[i]);

        press(4'b0100);
        check("left cursor", 32'(bus.cursor), 2);
        press(4'b0010);
        check("sec1 up wrap", 32'(bus.n_sec1), 0);
        press(4'b0001);
        check("sec1 down wrap", 32'(bus.n_sec1), 5);

        repeat (3) press(4'b0100);
        repeat (5) press(4'b0010);
        check("hrs0 edited", 32'(bus.n_hrs0), 7);
        press(4'b0100);
        press(4'b0010);
        check("hrs1 to 2", 32'(bus.n_hrs1), 2);
        check("hrs0 clamped", 32'(bus.n_hrs0), 3);
        press(4'b0010);
        check("hrs1 wrap", 32'(bus.n_hrs1), 0);

        press(4'b1000);
        check("commit step1", 32'(bus.cursor), 1);
        for (int s = 1; s < 6; s++) begin
            @(posedge clk); #1;
            check($sformatf("commit step%0d", s + 1), 32'(bus.cursor), 32'(1 << s));
            check("commit hold", 32'(bus.set_active), 1);
        end
        @(posedge clk); #1;
        check("commit end set_active", 32'(bus.set_active), 0);
        check("commit end cursor", 32'(bus.cursor), 0);
        for (int i = 0; i < 6; i++) check($sformatf("loaded digit%0d", i), 32'(tdig[i]), exp_new[i]);

        press(4'b1000);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("timeout pending", 32'(bus.cursor), 1);
        check("timeout pending active", 32'(bus.set_active), 1);
        @(posedge clk); #1;
        check("timeout edge", 32'(bus.cursor), 1);
        @(posedge clk); #1;
        check("timeout commit step2", 32'(bus.cursor), 2);
        repeat (5) @(posedge clk);
        #1;
        check("timeout back to run", 32'(bus.set_active), 0);

        press(4'b1010);
        check("mode+up enters set", 32'(bus.set_active), 1);
        check("mode+up no edit", 32'(bus.n_sec0), 6);
        press(4'b0100);
        press(4'b1010);
        check("mode+up commits", 32'(bus.cursor), 1);
        check("mode+up keeps sec1", 32'(bus.n_sec1), 5);
        repeat (2) @(posedge clk);
        #1;
        check("commit step3", 32'(bus.cursor), 4);
        #2 rst_n = 1'b0;
        #1;
        check("abort set_active", 32'(bus.set_active), 0);
        check("abort cursor", 32'(bus.cursor), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int it = 0; it < 1200; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                @(posedge clk); #3 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end else if (r < 7) begin
                repeat (TO + 5) @(negedge clk);
            end else begin
                if (!bus.set_active && $urandom_range(0, 3) == 0) begin
                    h1 = $urandom_range(0, 2);
                    set_time(h1, (h1 == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9),
                             $urandom_range(0, 5), $urandom_range(0, 9),
                             $urandom_range(0, 5), $urandom_range(0, 9));
                end
                r = $urandom_range(0, 99);
                if (r < 15)      mask = 4'($urandom_range(1, 15));
                else if (r < 30) mask = 4'b1000;
                else if (r < 55) mask = 4'b0100;
                else if (r < 80) mask = 4'b0010;
                else             mask = 4'b0001;
                @(negedge clk); btn = mask;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                btn = 4'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end

        btn = 4'b0;
        repeat (TO + 10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
